// File: rtl/usb_tx_scheduler.sv
// Transmit sequencer for usb_tx: arbitrates ACK > NAK > DATA requests, holds the packet code
// for one USB bit time, waits for EOP (with timeout), then enforces an inter-packet gap.
`timescale 1ns/1ps
module usb_tx_scheduler #(
  parameter int unsigned HoldCycles    = 9,
  parameter int unsigned GapCycles     = 17,
  parameter int unsigned TimeoutCycles = 8192,
  parameter int unsigned MaxSize       = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ack_req,
  input  logic       nak_req,
  input  logic       data_req,
  input  logic [6:0] data_size,
  input  logic       tx_done,
  output logic [1:0] tx_packet,
  output logic [6:0] tx_packet_size,
  output logic       busy,
  output logic       sent,
  output logic [1:0] sent_type,
  output logic       timeout_err
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {
    PktIdle = 2'b00,
    PktData = 2'b01,
    PktNak  = 2'b10,
    PktAck  = 2'b11
  } pkt_e;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ack_pend_q, ack_pend_d;
  logic            nak_pend_q, nak_pend_d;
  logic            data_pend_q, data_pend_d;
  logic [6:0]      pend_size_q, pend_size_d;
  pkt_e            gnt_q, gnt_d;
  pkt_e            tx_packet_q, tx_packet_d;
  logic [6:0]      tx_size_q, tx_size_d;
  logic            sent_q, sent_d;
  pkt_e            sent_type_q, sent_type_d;
  logic            tout_q, tout_d;
  pkt_e            gnt_code;
  logic [6:0]      size_clamped;

  assign size_clamped = (data_size > 7'(MaxSize)) ? 7'(MaxSize) : data_size;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    gnt_d       = gnt_q;
    tx_packet_d = tx_packet_q;
    tx_size_d   = tx_size_q;
    sent_d      = 1'b0;
    sent_type_d = sent_type_q;
    tout_d      = 1'b0;
    gnt_code    = PktIdle;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (ack_pend_q)       gnt_code = PktAck;
        else if (nak_pend_q)  gnt_code = PktNak;
        else if (data_pend_q) gnt_code = PktData;
        if (gnt_code != PktIdle) begin
          state_d     = StIssue;
          gnt_d       = gnt_code;
          tx_packet_d = gnt_code;
          if (gnt_code == PktData) tx_size_d = pend_size_q;
        end
      end
      StIssue: begin
        if (cnt_q == CntW'(HoldCycles - 1)) begin
          state_d     = StWaitDone;
          tx_packet_d = PktIdle;
          cnt_d       = '0;
        end
      end
      StWaitDone: begin
        // tx_done takes precedence over a coincident timeout expiry
        if (tx_done) begin
          state_d     = StGap;
          sent_d      = 1'b1;
          sent_type_d = gnt_q;
          cnt_d       = '0;
        end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          state_d = StGap;
          tout_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GapCycles - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A request arriving on its own grant edge stays pending for a later packet
    ack_pend_d  = (ack_pend_q && gnt_code != PktAck) || ack_req;
    nak_pend_d  = (nak_pend_q && gnt_code != PktNak) || nak_req;
    data_pend_d = (data_pend_q && gnt_code != PktData) || data_req;
    pend_size_d = data_req ? size_clamped : pend_size_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ack_pend_q  <= 1'b0;
      nak_pend_q  <= 1'b0;
      data_pend_q <= 1'b0;
      pend_size_q <= '0;
      gnt_q       <= PktIdle;
      tx_packet_q <= PktIdle;
      tx_size_q   <= '0;
      sent_q      <= 1'b0;
      sent_type_q <= PktIdle;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_pend_q  <= ack_pend_d;
      nak_pend_q  <= nak_pend_d;
      data_pend_q <= data_pend_d;
      pend_size_q <= pend_size_d;
      gnt_q       <= gnt_d;
      tx_packet_q <= tx_packet_d;
      tx_size_q   <= tx_size_d;
      sent_q      <= sent_d;
      sent_type_q <= sent_type_d;
      tout_q      <= tout_d;
    end
  end

  assign tx_packet      = tx_packet_q;
  assign tx_packet_size = tx_size_q;
  assign busy           = (state_q != StIdle);
  assign sent           = sent_q;
  assign sent_type      = sent_type_q;
  assign timeout_err    = tout_q;

endmodule
